// File: rtl/vector_reassembler.sv
// vector_reassembler: rebuilds a WIDTH-bit word from NUM_SLICES in-order
// SLICE_W-bit slices and holds it in a one-deep output buffer.
// Optional feature: define VREASM_PARITY_EN to check even parity (s_par) on
// every accepted slice; without it s_par is ignored.
//
// Handshake: a slice beat transfers on a cycle where s_valid && s_ready; a word
// transfers on a cycle where m_valid && m_ready. m_valid, once raised, holds
// until that transfer, and m_data is stable while m_valid is high.
module vector_reassembler #(
  parameter int WIDTH      = 41,
  parameter int SLICE_W    = 12,
  parameter int NUM_SLICES = 3,
  parameter int IDX_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IDX_W-1:0]   s_idx,
  input  logic [SLICE_W-1:0] s_data,
  input  logic               s_par,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               err,
  output logic [7:0]         frame_cnt
);

  localparam int ASM_W = (NUM_SLICES - 1) * SLICE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // cnt is the slice counter; 0 means waiting for the first slice
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [ASM_W-1:0] asm_reg;
  logic             accept;
  logic             par_bad;
  logic             load_slice;
  logic             complete;
  logic             err_nxt;
  logic [WIDTH-1:0] word;

  assign accept = s_valid && s_ready;

`ifdef VREASM_PARITY_EN
  assign par_bad = (^s_data) != s_par;
`else
  logic unused_par;
  assign unused_par = s_par;
  assign par_bad    = 1'b0;
`endif

  // Slice counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  // Next-state decode: in-order advance, completion, or error recovery
  always_comb begin
    cnt_nxt    = cnt;
    load_slice = 1'b0;
    complete   = 1'b0;
    err_nxt    = 1'b0;
    if (accept) begin
      if (par_bad) begin
        err_nxt = 1'b1;
        cnt_nxt = '0;
      end else if (s_idx == cnt) begin
        if (cnt == LAST_IDX) begin
          complete = 1'b1;
          cnt_nxt  = '0;
        end else begin
          load_slice = 1'b1;
          cnt_nxt    = cnt + 1'b1;
        end
      end else begin
        // Out-of-order beat: a slice 0 restarts the frame, anything else is dropped
        err_nxt = 1'b1;
        if (s_idx == '0) begin
          load_slice = 1'b1;
          cnt_nxt    = IDX_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
    end
  end

  // Output decode: stall only the final slice while the buffer stays occupied
  always_comb begin
    s_ready = !((cnt == LAST_IDX) && m_valid && !m_ready);
  end

  // Complete word: final slice on top of the collected lower slices, upper bits zero
  always_comb begin
    word = '0;
    word[ASM_W + SLICE_W - 1:0] = {s_data, asm_reg};
  end

  // Assembly register; loaded slices always land at their own index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg <= '0;
    end else if (load_slice) begin
      for (int i = 0; i < NUM_SLICES - 1; i++) begin
        if (s_idx == IDX_W'(i)) asm_reg[i*SLICE_W +: SLICE_W] <= s_data;
      end
    end
  end

  // Output buffer, error pulse and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      err <= err_nxt;
      if (complete) begin
        m_valid   <= 1'b1;
        m_data    <= word;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_reassembler.sv
// tb_vector_reassembler: directed scenarios plus randomized traffic, all
// checked against a slice-list model of the reassembly rules.
module tb_vector_reassembler;

  localparam int WIDTH      = 41;
  localparam int SLICE_W    = 12;
  localparam int NUM_SLICES = 3;
  localparam int IDX_W      = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [IDX_W-1:0]   s_idx = '0;
  logic [SLICE_W-1:0] s_data = '0;
  logic               s_par = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [WIDTH-1:0]   m_data;
  logic               err;
  logic [7:0]         frame_cnt;

  // Clock
  always #5 clk = ~clk;

  vector_reassembler #(
    .WIDTH(WIDTH), .SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_idx(s_idx), .s_data(s_data), .s_par(s_par),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err), .frame_cnt(frame_cnt)
  );

  // Reference model: slices collected so far, and words waiting for the sink
  logic [WIDTH-1:0]   exp_q[$];
  logic [SLICE_W-1:0] part_q[$];
  int                 exp_frames = 0;
  logic               exp_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic gp(input logic [SLICE_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic model_ready(input logic mr);
    return !(part_q.size() == NUM_SLICES - 1 && exp_q.size() != 0 && !mr);
  endfunction

  // Advance the model by one clock edge with the given inputs
  task automatic model_step(input logic v, input logic [IDX_W-1:0] idx,
                            input logic [SLICE_W-1:0] data, input logic par, input logic mr);
    logic             rdy;
    logic [WIDTH-1:0] w;
    rdy     = model_ready(mr);
    exp_err = 1'b0;
    if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
    if (v && rdy) begin
`ifdef VREASM_PARITY_EN
      if ((^data) != par) begin
        exp_err = 1'b1;
        part_q.delete();
      end else
`endif
      if (int'(idx) == part_q.size()) begin
        part_q.push_back(data);
        if (part_q.size() == NUM_SLICES) begin
          w = '0;
          foreach (part_q[i]) w[i*SLICE_W +: SLICE_W] = part_q[i];
          exp_q.push_back(w);
          exp_frames = (exp_frames + 1) % 256;
          part_q.delete();
        end
      end else begin
        exp_err = 1'b1;
        part_q.delete();
        if (idx == '0) part_q.push_back(data);
      end
    end
  endtask

  // Driver: one clock cycle of stimulus with full output checking
  task automatic cycle(input logic v, input logic [IDX_W-1:0] idx,
                       input logic [SLICE_W-1:0] data, input logic par, input logic mr);
    @(negedge clk);
    s_valid = v;
    s_idx   = idx;
    s_data  = data;
    s_par   = par;
    m_ready = mr;
    #1;
    chk("s_ready", s_ready, model_ready(mr));
    model_step(v, idx, data, par, mr);
    @(posedge clk);
    #1;
    chk("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    chk("err", err, exp_err);
    chk("frame_cnt", frame_cnt, exp_frames);
  endtask

  task automatic beat(input logic [IDX_W-1:0] idx, input logic [SLICE_W-1:0] data, input logic mr);
    cycle(1'b1, idx, data, gp(data), mr);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_s_ready", s_ready, 1);
    part_q.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_err    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SLICE_W-1:0] d;
    logic [IDX_W-1:0]   ix;
    logic               v, mr, p;

    apply_reset();

    // Basic frame with a ready sink
    beat(2'd0, 12'hABC, 1'b1);
    beat(2'd1, 12'h123, 1'b1);
    beat(2'd2, 12'hFFF, 1'b1);
    chk("t1_valid", m_valid, 1);
    chk("t1_word", m_data, 41'h0_FFF_123_ABC);
    chk("t1_frames", frame_cnt, 1);
    cycle(1'b0, 2'd0, 12'h0, 1'b0, 1'b1);

    // Final slice stalls behind a pending word, then loads as it leaves
    beat(2'd0, 12'h101, 1'b0);
    beat(2'd1, 12'h202, 1'b0);
    beat(2'd2, 12'h303, 1'b0);
    beat(2'd0, 12'h404, 1'b0);
    beat(2'd1, 12'h505, 1'b0);
    beat(2'd2, 12'h606, 1'b0);
    chk("t2_stall", s_ready, 0);
    beat(2'd2, 12'h606, 1'b0);
    beat(2'd2, 12'h606, 1'b1);
    chk("t2_hold", m_valid, 1);
    chk("t2_word", m_data, 41'h0_606_505_404);
    cycle(1'b0, 2'd0, 12'h0, 1'b0, 1'b1);

    // Skipped index: error, frame dropped, clean restart
    beat(2'd0, 12'h111, 1'b1);
    beat(2'd2, 12'h222, 1'b1);
    chk("t3_err", err, 1);
    chk("t3_no_word", m_valid, 0);
    beat(2'd0, 12'h333, 1'b1);
    beat(2'd1, 12'h444, 1'b1);
    beat(2'd2, 12'h555, 1'b1);
    chk("t3_word", m_data, 41'h0_555_444_333);

    // Repeated slice 0 restarts the frame with the new data
    beat(2'd0, 12'h0AA, 1'b1);
    beat(2'd1, 12'h0BB, 1'b1);
    beat(2'd0, 12'h0CC, 1'b1);
    chk("t4_err", err, 1);
    beat(2'd1, 12'h0DD, 1'b1);
    beat(2'd2, 12'h0EE, 1'b1);
    chk("t4_word", m_data, 41'h0_0EE_0DD_0CC);

    // Reset while a word is pending and a frame is half built
    beat(2'd0, 12'h777, 1'b0);
    beat(2'd1, 12'h888, 1'b0);
    beat(2'd2, 12'h999, 1'b0);
    beat(2'd0, 12'h123, 1'b0);
    beat(2'd1, 12'h456, 1'b0);
    apply_reset();
    beat(2'd0, 12'hDEF, 1'b1);
    beat(2'd1, 12'h9A0, 1'b1);
    beat(2'd2, 12'h5C1, 1'b1);
    chk("t5_word", m_data, 41'h0_5C1_9A0_DEF);
    chk("t5_frames", frame_cnt, 1);

    // Wrong parity on slice 1
    beat(2'd0, 12'h0F0, 1'b1);
    cycle(1'b1, 2'd1, 12'h00F, ~gp(12'h00F), 1'b1);
    beat(2'd2, 12'hF00, 1'b1);
`ifdef VREASM_PARITY_EN
    chk("t6_err_follow", err, 1);
`else
    chk("t6_word", m_data, 41'h0_F00_00F_0F0);
`endif

    // Randomized traffic, mostly in order, with occasional faults and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      v  = ($urandom_range(0, 3) != 0);
      ix = ($urandom_range(0, 9) < 8) ? IDX_W'(part_q.size()) : IDX_W'($urandom_range(0, 3));
      d  = SLICE_W'($urandom);
      p  = gp(d) ^ ($urandom_range(0, 24) == 0);
      mr = ($urandom_range(0, 2) != 0);
      cycle(v, ix, d, p, mr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
